// File: rtl/vga_object_engine_if.sv
// vga_object_engine_if: command bus for the VGA object engine.
// The master drives one object move command per clk when cmd_valid is high.
interface vga_object_engine_if #(
    parameter int N_OBJ = 4
);
    localparam int OW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    logic          cmd_valid;
    logic [OW-1:0] cmd_obj;
    logic [2:0]    cmd_dir;

    modport master (output cmd_valid, cmd_obj, cmd_dir);
    modport slave  (input  cmd_valid, cmd_obj, cmd_dir);
endinterface

// File: rtl/vga_object_engine.sv
// vga_object_engine: VGA timing, N frame-synchronous objects, priority render.
// Optional macro VGA_WRAP_EN: out-of-range moves wrap instead of clamping.
module vga_object_engine #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int N_OBJ    = 4,
    parameter int OBJ_W    = 32,
    parameter int OBJ_H    = 32,
    parameter int STEP     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_object_engine_if.slave   cmd,
    input  logic [12*N_OBJ-1:0]  obj_color,
    input  logic [11:0]          bg_color,
    output logic                 hsync,
    output logic                 vsync,
    output logic [3:0]           VGA_R,
    output logic [3:0]           VGA_G,
    output logic [3:0]           VGA_B,
    output logic                 frame_start
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);
    localparam int PW = ((XW > YW) ? XW : YW) + 2;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef logic signed [PW-1:0] pos_t;

    localparam pos_t ONE    = pos_t'(1);
    localparam pos_t ZERO   = pos_t'(0);
    localparam pos_t HT_M1  = pos_t'(HT - 1);
    localparam pos_t VT_M1  = pos_t'(VT - 1);
    localparam pos_t HA     = pos_t'(H_ACTIVE);
    localparam pos_t VA     = pos_t'(V_ACTIVE);
    localparam pos_t HS0    = pos_t'(H_ACTIVE + H_FP);
    localparam pos_t HS1    = pos_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam pos_t VS0    = pos_t'(V_ACTIVE + V_FP);
    localparam pos_t VS1    = pos_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam pos_t XMAX   = pos_t'(H_ACTIVE - OBJ_W);
    localparam pos_t YMAX   = pos_t'(V_ACTIVE - OBJ_H);
    localparam pos_t OW_P   = pos_t'(OBJ_W);
    localparam pos_t OH_P   = pos_t'(OBJ_H);
    localparam pos_t STEP_P = pos_t'(STEP);
    localparam pos_t HOME_Y = pos_t'((V_ACTIVE - OBJ_H) / 2);

    function automatic pos_t home_x(input int i);
        return pos_t'(i * H_ACTIVE / N_OBJ);
    endfunction

    function automatic pos_t mv(input pos_t p, input logic dec,
                                input logic inc, input pos_t lim);
        pos_t r;
        r = p;
        if (dec) r = p - STEP_P;
        if (inc) r = p + STEP_P;
`ifdef VGA_WRAP_EN
        if (r < ZERO)     r = lim;
        else if (r > lim) r = ZERO;
`else
        if (r < ZERO)     r = ZERO;
        else if (r > lim) r = lim;
`endif
        return r;
    endfunction

    logic [DW-1:0] div;
    logic          pen;
    logic          apply;
    logic          cmd_hit;
    pos_t          x, y;
    pos_t          ox  [N_OBJ];
    pos_t          oy  [N_OBJ];
    pos_t          nox [N_OBJ];
    pos_t          noy [N_OBJ];
    logic [2:0]    pend [N_OBJ];
    logic [11:0]   pix;
    logic [11:0]   rgb;

    assign pen     = (div == DW'(CLK_DIV - 1));
    assign apply   = pen && (x == ZERO) && (y == VA);
    assign cmd_hit = cmd.cmd_valid && (int'(cmd.cmd_obj) < N_OBJ);
    assign VGA_R   = rgb[11:8];
    assign VGA_G   = rgb[7:4];
    assign VGA_B   = rgb[3:0];

    // Free-running pixel enable divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div <= '0;
        else        div <= pen ? '0 : div + 1'b1;
    end

    // Raster counters, advanced once per pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= ZERO;
            y <= ZERO;
        end else if (pen) begin
            if (x == HT_M1) begin
                x <= ZERO;
                y <= (y == VT_M1) ? ZERO : y + ONE;
            end else begin
                x <= x + ONE;
            end
        end
    end

    // Next position of each object from its pending command.
    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            nox[i] = ox[i];
            noy[i] = oy[i];
            case (pend[i])
                3'd1: noy[i] = mv(oy[i], 1'b1, 1'b0, YMAX);
                3'd2: noy[i] = mv(oy[i], 1'b0, 1'b1, YMAX);
                3'd3: nox[i] = mv(ox[i], 1'b1, 1'b0, XMAX);
                3'd4: nox[i] = mv(ox[i], 1'b0, 1'b1, XMAX);
                3'd5: begin
                    nox[i] = home_x(i);
                    noy[i] = HOME_Y;
                end
                default: ;
            endcase
        end
    end

    // Object state: moves land at the vblank apply point; a command
    // arriving in that same clk is kept pending for the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_OBJ; i++) begin
                ox[i]   <= home_x(i);
                oy[i]   <= HOME_Y;
                pend[i] <= '0;
            end
        end else begin
            if (apply) begin
                for (int i = 0; i < N_OBJ; i++) begin
                    ox[i]   <= nox[i];
                    oy[i]   <= noy[i];
                    pend[i] <= '0;
                end
            end
            if (cmd_hit) pend[cmd.cmd_obj] <= cmd.cmd_dir;
        end
    end

    // Pixel colour: lowest-index covering object, else background.
    always_comb begin
        pix = '0;
        if (x < HA && y < VA) begin
            pix = bg_color;
            for (int i = N_OBJ - 1; i >= 0; i--) begin
                if (x >= ox[i] && x < ox[i] + OW_P &&
                    y >= oy[i] && y < oy[i] + OH_P)
                    pix = obj_color[12*i +: 12];
            end
        end
    end

    // Registered video outputs, one pixel behind the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pen && (x == HT_M1) && (y == VT_M1);
            if (pen) begin
                hsync <= !(x >= HS0 && x < HS1);
                vsync <= !(y >= VS0 && y < VS1);
                rgb   <= pix;
            end
        end
    end
endmodule

// File: tb/tb_vga_object_engine.sv
// tb_vga_object_engine: directed vectors on a shrunken raster (24x17 pixels)
// with three objects, plus hand sequences for commands and reset.
module tb_vga_object_engine;
    localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACTIVE = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int CLK_DIV = 2, N_OBJ = 3;
    localparam int OBJ_W = 4, OBJ_H = 4, STEP = 2;
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BUDGET = 2000;
`ifdef VGA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [11:0] C0 = 12'h111;
    localparam logic [11:0] C1 = 12'h222;
    localparam logic [11:0] C2 = 12'h333;
    localparam logic [11:0] BG = 12'h0A5;
    localparam logic [11:0] BK = 12'h000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsync, vsync, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [11:0] bg_color;
    logic [12*N_OBJ-1:0] obj_color;

    vga_object_engine_if #(.N_OBJ(N_OBJ)) cif ();

    vga_object_engine #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .N_OBJ(N_OBJ),
        .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .STEP(STEP)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .cmd(cif),
        .obj_color(obj_color),
        .bg_color(bg_color),
        .hsync(hsync),
        .vsync(vsync),
        .VGA_R(vga_r),
        .VGA_G(vga_g),
        .VGA_B(vga_b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Reference raster position: (sx,sy) is the pixel the outputs show now.
    int mcnt, mx, my, sx, sy;
    bit sv;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= 0; mx <= 0; my <= 0; sv <= 1'b0;
            sx <= 0; sy <= 0;
        end else if (mcnt == CLK_DIV - 1) begin
            mcnt <= 0;
            sx <= mx; sy <= my; sv <= 1'b1;
            if (mx == HT - 1) begin
                mx <= 0;
                my <= (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx <= mx + 1;
            end
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    typedef struct {
        int          px;
        int          py;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t tv[20];
    int   nvec = 0;
    int   nbad = 0;

    task automatic chk_int(input string nm, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [11:0] er,
                           input logic eh, input logic ev);
        logic [11:0] g;
        g = {vga_r, vga_g, vga_b};
        nvec++;
        if (g !== er || hsync !== eh || vsync !== ev) begin
            nbad++;
            $display("FAIL %s: got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
                     nm, g, hsync, vsync, er, eh, ev);
        end
    endtask

    task automatic wait_pixel(input int px, input int py, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk); #1;
            if (sv && sx == px && sy == py) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nvec++;
            nbad++;
            $display("FAIL wait(%0d,%0d): timeout after %0d clk", px, py, BUDGET);
        end
    endtask

    task automatic skip_to(input int px, input int py);
        bit ok;
        wait_pixel(px, py, ok);
    endtask

    task automatic px_chk(input int px, input int py, input logic [11:0] er);
        bit          ok;
        logic [11:0] g;
        wait_pixel(px, py, ok);
        if (ok) begin
            g = {vga_r, vga_g, vga_b};
            nvec++;
            if (g !== er) begin
                nbad++;
                $display("FAIL px(%0d,%0d): got rgb=%h, want %h", px, py, g, er);
            end
        end
    endtask

    task automatic send(input int o, input int d);
        int ov;
        ov = o;
        cif.cmd_obj   = ov[1:0];
        cif.cmd_dir   = d[2:0];
        cif.cmd_valid = 1'b1;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk_out(nm, BK, 1'b1, 1'b1);
        chk_int({nm, "_fs"}, int'(frame_start), 0);
    endtask

    initial begin
        int t, t0;
        bit ok;

        tv[0]  = '{0, 3, BG, 1'b1, 1'b1};
        tv[1]  = '{0, 4, C0, 1'b1, 1'b1};
        tv[2]  = '{4, 4, BG, 1'b1, 1'b1};
        tv[3]  = '{5, 4, C1, 1'b1, 1'b1};
        tv[4]  = '{16, 4, BK, 1'b1, 1'b1};
        tv[5]  = '{8, 5, C1, 1'b1, 1'b1};
        tv[6]  = '{9, 5, BG, 1'b1, 1'b1};
        tv[7]  = '{18, 5, BK, 1'b0, 1'b1};
        tv[8]  = '{20, 5, BK, 1'b0, 1'b1};
        tv[9]  = '{21, 5, BK, 1'b1, 1'b1};
        tv[10] = '{10, 6, C2, 1'b1, 1'b1};
        tv[11] = '{3, 7, C0, 1'b1, 1'b1};
        tv[12] = '{13, 7, C2, 1'b1, 1'b1};
        tv[13] = '{14, 7, BG, 1'b1, 1'b1};
        tv[14] = '{5, 8, BG, 1'b1, 1'b1};
        tv[15] = '{15, 11, BG, 1'b1, 1'b1};
        tv[16] = '{0, 12, BK, 1'b1, 1'b1};
        tv[17] = '{0, 13, BK, 1'b1, 1'b0};
        tv[18] = '{23, 14, BK, 1'b1, 1'b0};
        tv[19] = '{0, 15, BK, 1'b1, 1'b1};

        obj_color     = {C2, C1, C0};
        bg_color      = BG;
        cif.cmd_valid = 1'b0;
        cif.cmd_obj   = '0;
        cif.cmd_dir   = '0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset_idle");
        rst_n = 1'b1;

        t = 0;
        while (hsync === 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
        chk_int("hs_first_fall", t, 2 * (H_ACTIVE + H_FP + 1));
        t0 = t;
        while (hsync === 1'b0 && t < 300) begin @(posedge clk); #1; t++; end
        chk_int("hs_low", t - t0, 2 * H_SYNC);
        while (hsync === 1'b1 && t < 300) begin @(posedge clk); #1; t++; end
        chk_int("hs_period", t - t0, 2 * HT);
        while (frame_start !== 1'b1 && t < 3000) begin @(posedge clk); #1; t++; end
        chk_int("fs_first", t, 2 * HT * VT);
        t0 = t;
        @(posedge clk); #1; t++;
        chk_int("fs_width", int'(frame_start), 0);
        while (frame_start !== 1'b1 && t < 5000) begin @(posedge clk); #1; t++; end
        chk_int("fs_period", t - t0, 2 * HT * VT);

        for (int i = 0; i < 20; i++) begin
            wait_pixel(tv[i].px, tv[i].py, ok);
            if (ok)
                chk_out($sformatf("vec%0d(%0d,%0d)", i, tv[i].px, tv[i].py),
                        tv[i].rgb, tv[i].hs, tv[i].vs);
        end

        skip_to(0, 1);
        send(1, 4); send(1, 4); send(1, 4);
        send(2, 3); send(2, 0);
        send(0, 3);
        send(3, 4);
        px_chk(6, 4, C1);
        skip_to(0, V_ACTIVE + 1);
        px_chk(0, 4, WRAP ? BG : C0);
        px_chk(6, 4, BG);
        px_chk(7, 4, C1);
        px_chk(10, 4, C1);
        px_chk(11, 4, C2);
        px_chk(12, 4, WRAP ? C0 : C2);
        px_chk(14, 4, WRAP ? C0 : BG);

        for (int k = 0; k < 3; k++) begin
            skip_to(0, 1);
            send(1, 3);
        end
        skip_to(0, V_ACTIVE + 1);
        px_chk(0, 4, WRAP ? BG : C0);
        px_chk(1, 4, WRAP ? C1 : C0);
        px_chk(3, 4, WRAP ? C1 : C0);
        px_chk(4, 4, C1);
        px_chk(5, 4, BG);

        skip_to(0, 1);
        send(1, 5);
        send(2, 2);
        skip_to(0, V_ACTIVE + 1);
        px_chk(4, 4, BG);
        px_chk(5, 4, C1);
        px_chk(10, 5, BG);
        px_chk(10, 9, C2);
        px_chk(10, 10, BG);

        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk); #1;
            if (mcnt == CLK_DIV - 1 && mx == 0 && my == V_ACTIVE) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nvec++;
            nbad++;
            $display("FAIL apply_wait: timeout after %0d clk", BUDGET);
        end
        send(2, 1);
        px_chk(10, 5, BG);
        px_chk(10, 9, C2);
        skip_to(0, V_ACTIVE + 1);
        px_chk(10, 5, C2);
        px_chk(10, 9, BG);

        skip_to(0, 1);
        send(1, 4);
        skip_to(0, V_ACTIVE + 1);
        skip_to(0, 1);
        send(0, 4);
        px_chk(9, 4, C1);
        skip_to(9, 5);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("reset_mid");
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset_hold");
        rst_n = 1'b1;
        px_chk(0, 4, C0);
        px_chk(4, 4, BG);
        px_chk(5, 4, C1);
        px_chk(9, 4, BG);
        px_chk(10, 4, C2);
        skip_to(0, V_ACTIVE + 1);
        px_chk(0, 4, C0);
        px_chk(4, 4, BG);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
